// File: rtl/redmule_pkg.sv
// Shared types and default widths for the RedMulE streamer-side address sequencers.
package redmule_pkg;

    localparam int unsigned TileSeqNumLoops = 3;
    localparam int unsigned TileSeqAddrW    = 32;
    localparam int unsigned TileSeqCntW     = 16;
    localparam int unsigned TileSeqLenW     = 8;
    localparam int unsigned TileSeqTileW    = 16;

    typedef logic [1:0] tile_seq_state_e;

    localparam tile_seq_state_e StIdle     = 2'd0;
    localparam tile_seq_state_e StIssue    = 2'd1;
    localparam tile_seq_state_e StWait     = 2'd2;
    localparam tile_seq_state_e StFinished = 2'd3;

    // Default-width view of a sequencer job configuration.
    typedef struct packed {
        logic [TileSeqAddrW-1:0]                      base;
        logic [TileSeqNumLoops-1:0][TileSeqCntW-1:0]  bound;
        logic [TileSeqNumLoops-1:0][TileSeqAddrW-1:0] stride;
        logic [TileSeqLenW-1:0]                       len;
        logic [TileSeqLenW-1:0]                       last_len;
        logic                                         pack;
        logic [TileSeqTileW-1:0]                      tot_tiles;
    } tile_seq_cfg_t;

endpackage

// File: rtl/redmule_loop_counter.sv
// One loop level: iteration counter plus running byte offset, stepped by the carry chain.
module redmule_loop_counter #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              init_i,
    input  logic              step_i,
    input  logic [CNT_W-1:0]  bound_i,
    input  logic [ADDR_W-1:0] stride_i,
    output logic [ADDR_W-1:0] offset_o,
    output logic              at_last_o
);

    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] offset_q;

    // bound_i is never 0 once latched, so bound-1 is the final iteration.
    assign at_last_o = (cnt_q == bound_i - CNT_W'(1));
    assign offset_o  = offset_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || init_i) begin
            cnt_q    <= '0;
            offset_q <= '0;
        end else if (step_i) begin
            if (at_last_o) begin
                cnt_q    <= '0;
                offset_q <= '0;
            end else begin
                cnt_q    <= cnt_q + CNT_W'(1);
                offset_q <= offset_q + stride_i;
            end
        end
    end

endmodule

// File: rtl/redmule_tile_addr_sequencer.sv
// Issues one streamer start request per tile while walking NUM_LOOPS nested address loops.
module redmule_tile_addr_sequencer
    import redmule_pkg::*;
#(
    parameter int unsigned NUM_LOOPS = TileSeqNumLoops,
    parameter int unsigned ADDR_W    = TileSeqAddrW,
    parameter int unsigned CNT_W     = TileSeqCntW,
    parameter int unsigned LEN_W     = TileSeqLenW,
    parameter int unsigned TILE_W    = TileSeqTileW
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          start_i,
    input  logic [ADDR_W-1:0]             cfg_base_addr_i,
    input  logic [NUM_LOOPS*CNT_W-1:0]    cfg_bound_i,
    input  logic [NUM_LOOPS*ADDR_W-1:0]   cfg_stride_i,
    input  logic [LEN_W-1:0]              cfg_len_i,
    input  logic [LEN_W-1:0]              cfg_last_len_i,
    input  logic                          cfg_pack_i,
    input  logic [TILE_W-1:0]             cfg_tot_tiles_i,
    input  logic                          ready_start_i,
    input  logic                          done_i,
    output logic                          req_start_o,
    output logic [ADDR_W-1:0]             base_addr_o,
    output logic [LEN_W-1:0]              tot_len_o,
    output logic [TILE_W-1:0]             tile_idx_o,
    output logic                          busy_o,
    output logic                          finished_o
);

    typedef struct packed {
        logic [ADDR_W-1:0]                 base;
        logic [NUM_LOOPS-1:0][CNT_W-1:0]   bound;
        logic [NUM_LOOPS-1:0][ADDR_W-1:0]  stride;
        logic [LEN_W-1:0]                  len;
        logic [LEN_W-1:0]                  last_len;
        logic                              pack;
        logic [TILE_W-1:0]                 tot_tiles;
    } cfg_t;

    tile_seq_state_e                  state_q, state_d;
    cfg_t                             cfg_q, cfg_d;
    logic [TILE_W-1:0]                tile_q, tile_d;
    logic                             soft_rst;
    logic                             load;
    logic                             advance;
    logic [NUM_LOOPS-1:0]             step;
    logic [NUM_LOOPS-1:0]             at_last;
    logic [NUM_LOOPS-1:0][ADDR_W-1:0] offset;
    logic [NUM_LOOPS-1:0][CNT_W-1:0]  bound_in;
    logic [LEN_W-1:0]                 raw_len;
    logic [LEN_W:0]                   packed_len;

    assign soft_rst = rst_i | clear_i;
    assign bound_in = cfg_bound_i;

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        tile_d      = tile_q;
        load        = 1'b0;
        advance     = 1'b0;
        req_start_o = 1'b0;
        unique case (state_q)
            StIdle, StFinished: begin
                if (start_i) begin
                    load           = 1'b1;
                    tile_d         = '0;
                    cfg_d.base     = cfg_base_addr_i;
                    cfg_d.stride   = cfg_stride_i;
                    cfg_d.len      = cfg_len_i;
                    cfg_d.last_len = cfg_last_len_i;
                    cfg_d.pack     = cfg_pack_i;
                    cfg_d.tot_tiles = cfg_tot_tiles_i;
                    for (int i = 0; i < NUM_LOOPS; i++) begin
                        cfg_d.bound[i] = (bound_in[i] == '0) ? CNT_W'(1) : bound_in[i];
                    end
                    state_d = (cfg_tot_tiles_i == '0) ? StFinished : StIssue;
                end
            end
            StIssue: begin
                req_start_o = ready_start_i;
                if (ready_start_i) state_d = StWait;
            end
            StWait: begin
                if (done_i) begin
                    // The final tile leaves counters untouched so outputs hold in FINISHED.
                    if (tile_q + TILE_W'(1) == cfg_q.tot_tiles) begin
                        state_d = StFinished;
                    end else begin
                        advance = 1'b1;
                        tile_d  = tile_q + TILE_W'(1);
                        state_d = StIssue;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            state_q <= StIdle;
            cfg_q   <= '0;
            tile_q  <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            tile_q  <= tile_d;
        end
    end

    // Loop i steps only when every inner loop is on its final iteration.
    always_comb begin
        step[0] = advance;
        for (int i = 1; i < NUM_LOOPS; i++) begin
            step[i] = step[i-1] & at_last[i-1];
        end
    end

    for (genvar g = 0; g < NUM_LOOPS; g++) begin : gen_loop
        redmule_loop_counter #(
            .CNT_W  (CNT_W),
            .ADDR_W (ADDR_W)
        ) u_loop (
            .clk_i     (clk_i),
            .rst_i     (soft_rst),
            .init_i    (load),
            .step_i    (step[g]),
            .bound_i   (cfg_q.bound[g]),
            .stride_i  (cfg_q.stride[g]),
            .offset_o  (offset[g]),
            .at_last_o (at_last[g])
        );
    end

    always_comb begin
        base_addr_o = cfg_q.base;
        for (int i = 0; i < NUM_LOOPS; i++) begin
            base_addr_o = base_addr_o + offset[i];
        end
    end

    always_comb begin
        raw_len    = (at_last[NUM_LOOPS-1] && cfg_q.last_len != '0) ? cfg_q.last_len : cfg_q.len;
        packed_len = ({1'b0, raw_len} + (LEN_W+1)'(1)) >> 1;
        tot_len_o  = cfg_q.pack ? packed_len[LEN_W-1:0] : raw_len;
    end

    assign tile_idx_o = tile_q;
    assign busy_o     = (state_q == StIssue) || (state_q == StWait);
    assign finished_o = (state_q == StFinished);

endmodule

// File: tb/tb_redmule_tile_addr_sequencer.sv
// Directed bench for the tile address sequencer with hand-computed tile sequences.
module tb_redmule_tile_addr_sequencer;

    logic        clk = 1'b0;
    logic        rst, clear, start, ready, done;
    logic [31:0] cfg_base;
    logic [47:0] cfg_bound;
    logic [95:0] cfg_stride;
    logic [7:0]  cfg_len, cfg_last_len;
    logic        cfg_pack;
    logic [15:0] cfg_tot;
    logic        req, busy, fin;
    logic [31:0] base_addr;
    logic [7:0]  tot_len;
    logic [15:0] tile_idx;

    int n_checks = 0;
    int n_pass   = 0;

    int unsigned m_b [3];
    int unsigned m_s [3];
    int unsigned m_base, m_len, m_last, m_pack, m_tot;

    logic [31:0] basic_addr [12] = '{
        32'h1000, 32'h1040, 32'h1100, 32'h1140, 32'h1200, 32'h1240,
        32'h2000, 32'h2040, 32'h2100, 32'h2140, 32'h2200, 32'h2240
    };

    always #5 clk = ~clk;

    redmule_tile_addr_sequencer #(
        .NUM_LOOPS (3),
        .ADDR_W    (32),
        .CNT_W     (16),
        .LEN_W     (8),
        .TILE_W    (16)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .clear_i         (clear),
        .start_i         (start),
        .cfg_base_addr_i (cfg_base),
        .cfg_bound_i     (cfg_bound),
        .cfg_stride_i    (cfg_stride),
        .cfg_len_i       (cfg_len),
        .cfg_last_len_i  (cfg_last_len),
        .cfg_pack_i      (cfg_pack),
        .cfg_tot_tiles_i (cfg_tot),
        .ready_start_i   (ready),
        .done_i          (done),
        .req_start_o     (req),
        .base_addr_o     (base_addr),
        .tot_len_o       (tot_len),
        .tile_idx_o      (tile_idx),
        .busy_o          (busy),
        .finished_o      (fin)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic set_cfg(input logic [31:0] base, input logic [15:0] b0, input logic [15:0] b1,
                           input logic [15:0] b2, input logic [31:0] s0, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [7:0] len, input logic [7:0] last,
                           input logic pk, input logic [15:0] tot);
        cfg_base     = base;
        cfg_bound    = {b2, b1, b0};
        cfg_stride   = {s2, s1, s0};
        cfg_len      = len;
        cfg_last_len = last;
        cfg_pack     = pk;
        cfg_tot      = tot;
        m_base = base;
        m_b[0] = (b0 == 0) ? 1 : b0;
        m_b[1] = (b1 == 0) ? 1 : b1;
        m_b[2] = (b2 == 0) ? 1 : b2;
        m_s[0] = s0;
        m_s[1] = s1;
        m_s[2] = s2;
        m_len  = len;
        m_last = last;
        m_pack = pk;
        m_tot  = tot;
    endtask

    function automatic logic [31:0] model_addr(input int unsigned k);
        int unsigned c0, c1, c2;
        c0 = k % m_b[0];
        c1 = (k / m_b[0]) % m_b[1];
        c2 = (k / (m_b[0] * m_b[1])) % m_b[2];
        return m_base + c0 * m_s[0] + c1 * m_s[1] + c2 * m_s[2];
    endfunction

    function automatic logic [7:0] model_len(input int unsigned k);
        int unsigned c2, raw;
        c2  = (k / (m_b[0] * m_b[1])) % m_b[2];
        raw = (c2 == m_b[2] - 1 && m_last != 0) ? m_last : m_len;
        if (m_pack != 0) raw = (raw + 1) / 2;
        return raw[7:0];
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_req();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (req) ok = 1'b1;
            else @(negedge clk);
        end
        check("req_seen", ok, 1);
    endtask

    // Request at this negedge, handshake on the next posedge, done 3 cycles after the request.
    task automatic serve_tile(input logic [31:0] addr, input logic [7:0] len, input int idx);
        wait_req();
        check("base_addr", base_addr, addr);
        check("tot_len", tot_len, {24'd0, len});
        check("tile_idx", tile_idx, idx);
        check("busy", busy, 1);
        @(negedge clk);
        check("req_low_in_wait", req, 0);
        repeat (2) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic run_model_job();
        for (int unsigned k = 0; k < m_tot; k++) serve_tile(model_addr(k), model_len(k), k);
        check("finished", fin, 1);
    endtask

    task automatic hit_in_wait(input bit use_rst, input int idx);
        wait_req();
        check("hit_idx", tile_idx, idx);
        @(negedge clk);
        done = 1'b1;
        if (use_rst) rst = 1'b1;
        else clear = 1'b1;
        @(negedge clk);
        done  = 1'b0;
        rst   = 1'b0;
        clear = 1'b0;
        check("idle_req", req, 0);
        check("idle_base", base_addr, 0);
        check("idle_len", tot_len, 0);
        check("idle_idx", tile_idx, 0);
        check("idle_busy", busy, 0);
        check("idle_fin", fin, 0);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; start = 1'b0; ready = 1'b1; done = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_req", req, 0);
        check("rst_base", base_addr, 0);
        check("rst_len", tot_len, 0);
        check("rst_idx", tile_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_fin", fin, 0);

        // Basic 3-loop job
        set_cfg(32'h1000, 2, 3, 2, 32'h40, 32'h100, 32'h1000, 16, 0, 0, 12);
        pulse_start();
        for (int k = 0; k < 12; k++) serve_tile(basic_addr[k], 16, k);
        check("basic_fin", fin, 1);
        check("basic_busy", busy, 0);
        check("basic_hold_addr", base_addr, 32'h2240);
        check("basic_hold_idx", tile_idx, 11);
        check("basic_req", req, 0);

        // Leftover length, restarted straight from FINISHED
        set_cfg(32'h1000, 2, 3, 2, 32'h40, 32'h100, 32'h1000, 16, 5, 0, 12);
        pulse_start();
        check("restart_no_dead", req, 1);
        run_model_job();
        set_cfg(32'h1000, 2, 3, 2, 32'h40, 32'h100, 32'h1000, 16, 5, 1, 12);
        pulse_start();
        run_model_job();

        // Handshake stall
        ready = 1'b0;
        set_cfg(32'h3000, 1, 1, 1, 0, 0, 0, 9, 0, 0, 1);
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            check("stall_req", req, 0);
            check("stall_addr", base_addr, 32'h3000);
            @(negedge clk);
        end
        ready = 1'b1;
        #1;
        check("stall_fire", req, 1);
        @(negedge clk);
        check("stall_wait", req, 0);
        repeat (2) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("stall_fin", fin, 1);

        // Regfile cleared right after start
        set_cfg(32'h1000, 2, 3, 2, 32'h40, 32'h100, 32'h1000, 16, 0, 0, 12);
        pulse_start();
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) serve_tile(basic_addr[k], 16, k);
        check("cfgclr_fin", fin, 1);

        // Zero tiles
        set_cfg(32'h4000, 1, 1, 1, 0, 0, 0, 4, 0, 0, 0);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            check("zero_req", req, 0);
            check("zero_fin", fin, 1);
            check("zero_busy", busy, 0);
            @(negedge clk);
        end

        // Bound 0 on loop 1 acts as bound 1
        set_cfg(32'h1000, 2, 0, 2, 32'h40, 32'h100, 32'h1000, 16, 0, 0, 4);
        pulse_start();
        serve_tile(32'h1000, 16, 0);
        serve_tile(32'h1040, 16, 1);
        serve_tile(32'h2000, 16, 2);
        serve_tile(32'h2040, 16, 3);
        check("b0_fin", fin, 1);

        // Packed maximum length
        set_cfg(0, 1, 1, 1, 0, 0, 0, 255, 0, 1, 1);
        pulse_start();
        serve_tile(0, 128, 0);

        // Address wrap
        set_cfg(32'hFFFF_FFC0, 2, 1, 1, 32'h40, 0, 0, 4, 0, 0, 2);
        pulse_start();
        serve_tile(32'hFFFF_FFC0, 4, 0);
        serve_tile(32'h0000_0000, 4, 1);

        // Clear in WAIT with done, late done in IDLE, then rerun; same with rst
        set_cfg(32'h1000, 2, 3, 2, 32'h40, 32'h100, 32'h1000, 16, 0, 0, 12);
        pulse_start();
        hit_in_wait(1'b0, 0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("late_done_busy", busy, 0);
        check("late_done_idx", tile_idx, 0);
        pulse_start();
        serve_tile(32'h1000, 16, 0);
        serve_tile(32'h1040, 16, 1);
        hit_in_wait(1'b1, 2);
        pulse_start();
        serve_tile(32'h1000, 16, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/redmule_tile_addr_sequencer.md
Name: redmule_tile_addr_sequencer

Overview:
- Parametrised, self-contained tile-request sequencer for one streamer source port.
- Walks NUM_LOOPS nested loops, each with its own runtime bound and byte stride, and issues one start request per tile with base address and length.
- Handles a leftover length on the last outer iteration, MX packed-length halving, and a total-tile limit.
- Latches its whole configuration at start, so the regfile may be cleared mid-job. Intended to replace the hard-wired X/W/Z iteration logic in the scheduler, one instance per stream.

Parameters:
NUM_LOOPS, 3, number of nested loop levels (loop 0 innermost), >=1
ADDR_W, 32, address and stride width
CNT_W, 16, loop-counter and bound width
LEN_W, 8, tot_len width in beats
TILE_W, 16, tile counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
clear_i  in  1  synchronous soft clear, same effect as rst_i
start_i  in  1  one-cycle pulse, latches cfg_*, honoured only in IDLE or FINISHED
cfg_base_addr_i  in  ADDR_W  job base address
cfg_bound_i  in  NUM_LOOPS*CNT_W  iteration count per loop, slice i = loop i
cfg_stride_i  in  NUM_LOOPS*ADDR_W  byte increment per iteration of loop i
cfg_len_i  in  LEN_W  nominal beats per tile
cfg_last_len_i  in  LEN_W  beats per tile on last outermost iteration, 0 = use cfg_len_i
cfg_pack_i  in  1  MX packed mode: emitted length = ceil(len/2)
cfg_tot_tiles_i  in  TILE_W  tiles to issue before finishing
ready_start_i  in  1  streamer ready_start
done_i  in  1  streamer done pulse for the outstanding tile
req_start_o  out  1  streamer req_start
base_addr_o  out  ADDR_W  tile base address
tot_len_o  out  LEN_W  tile length in beats
tile_idx_o  out  TILE_W  index of current tile
busy_o  out  1  job active (ISSUE or WAIT)
finished_o  out  1  all tiles completed

Behaviour:
- Reset values: rst_i or clear_i puts the FSM in IDLE and zeroes every counter, offset and latched cfg. All outputs are 0. clear_i wins over start_i and done_i in the same cycle.
- FSM states:
  - IDLE: on start_i, latch cfg, zero counters and offsets. Go to FINISHED if cfg_tot_tiles_i==0, else ISSUE.
  - ISSUE: req_start_o = ready_start_i, combinational. A cycle with req_start_o=1 is the handshake; next state is WAIT. done_i is ignored in ISSUE.
  - WAIT: wait for done_i (pulse width of several cycles is not allowed). On done_i, advance the counters (below) and increment tile_idx. If tile_idx+1 == tot_tiles, go to FINISHED, else go to ISSUE. The next request can therefore be asserted at the earliest 1 cycle after done_i.
  - FINISHED: finished_o=1, busy_o=0. start_i restarts the job exactly as from IDLE, with no dead cycle.
- Counter advance (ripple carry, all in one cycle):
  - Loop 0 always steps.
  - Loop i steps only if all loops below it are at bound-1.
  - A stepping loop at bound-1 wraps its counter and offset to 0; otherwise counter +1 and offset += stride.
  - After the outermost loop wraps, the loops restart from 0 and the job continues until tot_tiles is reached.
  - A latched bound of 0 is treated as 1.
- base_addr_o = base + sum of all loop offsets, mod 2^ADDR_W.
  - Computed combinationally from registers, so it is stable while req_start_o may assert.
  - Offsets are held in ADDR_W-bit registers, so no multiplier is needed.
- Length selection: the raw length is last_len when the outermost counter == bound-1 and last_len != 0, otherwise len.
  - With pack set, tot_len_o = (raw+1)>>1, computed at LEN_W+1 bits so raw = 2^LEN_W-1 does not overflow.
- Outputs base_addr_o, tot_len_o and tile_idx_o are valid in ISSUE and WAIT, and are held at their last values in FINISHED.
- start_i in ISSUE or WAIT is ignored; cfg changes have no effect after latching.
- Reset mid-job (ISSUE or WAIT) returns to IDLE. A late done_i arriving in IDLE is ignored.

Decomposition:
- redmule_pkg gains a tile_seq_cfg_t struct (base, bound[], stride[], len, last_len, pack, tot_tiles), a tile_seq_state_e enum {IDLE, ISSUE, WAIT, FINISHED}, and default widths.
- One sub-module, redmule_loop_counter: CNT_W counter plus ADDR_W offset with step/wrap, instantiated NUM_LOOPS times in a generate loop, with carry chaining between instances.

Test Plan:
- Basic 3-loop job:
  - Config: base=0x1000, bounds={2,3,2} (loop0..2), strides={0x40,0x100,0x1000}, len=16, tot_tiles=12, ready always high, done 3 cycles after each request.
  - Expected addresses in order: 0x1000, 0x1040, 0x1100, 0x1140, 0x1200, 0x1240, 0x2000, …, last 0x2240.
  - finished_o rises on the cycle after the 12th done_i.
- Leftover length: same config with last_len=5. The first 6 tiles have len 16 and the last 6 have len 5. Adding pack=1 gives 8 and 3.
- Handshake stall: ready_start_i held low for 10 cycles in ISSUE. req_start_o stays 0 and base_addr_o is stable; the request fires in the first cycle ready_start_i=1.
- Regfile clear after start: cfg_* inputs are driven to 0 one cycle after start_i. The emitted sequence is identical to the basic job.
- Edge cases:
  - tot_tiles=0 goes IDLE to FINISHED with no req_start_o.
  - bound=0 on loop 1 behaves as bound 1.
  - len=255 with pack gives 128.
  - Address wrap: base=0xFFFF_FFC0 with stride 0x40 yields 0x0000_0000.
- Reset and clear: clear_i asserted in WAIT together with done_i gives IDLE, all outputs 0, and tile_idx not incremented. A new start_i then runs the job from tile 0. Same check with rst_i.
